// File: rtl/fp16_pkg.sv
// fp16_pkg: shared definitions for the FP16 multicycle datapath.
//   Field positions of the IEEE-754 half-precision word, arithmetic constants,
//   the accumulator state encoding and the hidden-bit mantissa helper.
package fp16_pkg;

    // Field positions inside a 16-bit half-precision word.
    localparam int unsigned SIGN    = 15;
    localparam int unsigned EXP_HI  = 14;
    localparam int unsigned EXP_LO  = 10;
    localparam int unsigned FRAC_HI = 9;
    localparam int unsigned FRAC_LO = 0;

    localparam int unsigned MANT_W  = 11;  // hidden bit + 10 fraction bits
    localparam int unsigned SUM_W   = 12;  // one carry bit above the mantissa
    localparam int unsigned EXPW_W  = 6;   // working exponent, room to detect 31

    localparam logic [4:0]  EXP_MAX   = 5'd31;
    localparam logic [15:0] FP16_MAXF = 16'h7BFF;
    localparam logic [15:0] FP16_ZERO = 16'h0000;

    typedef enum logic [2:0] {
        StIdle,
        StCmp,
        StAlign,
        StAdd,
        StNorm,
        StDone
    } accState_t;

    // 11-bit mantissa with the implicit leading one restored.
    function automatic logic [MANT_W-1:0] hiddenMant(input logic [9:0] frac);
        return {1'b1, frac};
    endfunction

endpackage

// File: rtl/fp16_norm_step.sv
// fp16_norm_step: combinational single-step normalizer for the accumulator.
//   Ports:
//     sumIn     [11:0] unnormalized magnitude (bit 10 is the hidden-bit position)
//     expIn     [5:0]  working exponent of sumIn
//     sumOut    [11:0] magnitude after at most one shift
//     expOut    [5:0]  exponent after at most one adjustment
//     isZero           sumIn is zero, result is positive zero
//     isNormal         sumIn already has its leading one in bit 10
//     overflow         the right shift pushed the exponent to 31 or beyond
//     underflow        the left shift pushed the exponent to 0 (flush)
module fp16_norm_step
    import fp16_pkg::*;
(
    input  logic [SUM_W-1:0]  sumIn,
    input  logic [EXPW_W-1:0] expIn,
    output logic [SUM_W-1:0]  sumOut,
    output logic [EXPW_W-1:0] expOut,
    output logic              isZero,
    output logic              isNormal,
    output logic              overflow,
    output logic              underflow
);

    always_comb begin
        sumOut    = sumIn;
        expOut    = expIn;
        isZero    = 1'b0;
        isNormal  = 1'b0;
        overflow  = 1'b0;
        underflow = 1'b0;
        if (sumIn == '0) begin
            isZero = 1'b1;
        end else if (sumIn[SUM_W-1]) begin
            // Carry out of the add: shift right (truncating) and bump the exponent.
            sumOut   = sumIn >> 1;
            expOut   = expIn + 6'd1;
            overflow = (expIn + 6'd1) >= {1'b0, EXP_MAX};
        end else if (sumIn[SUM_W-2]) begin
            isNormal = 1'b1;
        end else begin
            sumOut    = sumIn << 1;
            expOut    = expIn - 6'd1;
            underflow = (expIn <= 6'd1);
        end
    end

endmodule

// File: rtl/fp_acc_16.sv
// fp_acc_16: multicycle FP16 accumulator (running sum of incoming operands).
//   Truncating arithmetic, subnormals flushed to zero, no NaN/Inf handling.
//   Sequence per operand: CMP -> ALIGN (1 bit/cycle) -> ADD -> NORM (1 step/cycle) -> DONE.
//   Ports:
//     clk       clock, rising edge
//     reset     synchronous active-high reset
//     clear     synchronous accumulator clear, aborts any operand in flight
//     in_valid  din valid
//     in_ready  block can accept din this cycle (IDLE only, not during clear/reset)
//     din       FP16 operand
//     acc       registered accumulator value
//     busy      high in every state except IDLE
//     done      one-cycle pulse once acc reflects the last accepted operand
//   Parameter SAT_OVF: 1 = overflow saturates to +/-0x7BFF, 0 = overflow gives +/-inf.
module fp_acc_16
    import fp16_pkg::*;
#(
    parameter bit SAT_OVF = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] din,
    output logic [15:0] acc,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] ALIGN_LIMIT = 5'd11;

    accState_t         state;
    logic [15:0]       opReg;
    logic [MANT_W-1:0] mantL;
    logic [MANT_W-1:0] mantS;
    logic              signL;
    logic              signS;
    logic [EXPW_W-1:0] expWork;
    logic [SUM_W-1:0]  sumReg;
    logic [4:0]        alignCnt;

    // Operand classification and ordering used in CMP.
    logic        opIsZero;
    logic        accIsZero;
    logic        opIsLarger;
    logic [15:0] lVal;
    logic [15:0] sVal;
    logic [4:0]  expDiff;
    logic        alignSkip;

    // ADD and NORM datapath.
    logic [SUM_W-1:0]  addSum;
    logic [SUM_W-1:0]  normSum;
    logic [EXPW_W-1:0] normExp;
    logic              normZero;
    logic              normDone;
    logic              normOvf;
    logic              normUnf;
    logic [15:0]       ovfValue;

    assign in_ready = (state == StIdle) && !clear && !reset;

    assign opIsZero   = (opReg[EXP_HI:EXP_LO] == '0);
    assign accIsZero  = (acc[EXP_HI:EXP_LO] == '0);
    // Ties keep the accumulator as the larger operand.
    assign opIsLarger = (opReg[EXP_HI:0] > acc[EXP_HI:0]);
    assign lVal       = opIsLarger ? opReg : acc;
    assign sVal       = opIsLarger ? acc : opReg;
    assign expDiff    = lVal[EXP_HI:EXP_LO] - sVal[EXP_HI:EXP_LO];
    assign alignSkip  = (expDiff >= ALIGN_LIMIT);

    // mantL >= mantS after alignment, so the subtraction never goes negative.
    assign addSum = (signL == signS) ? ({1'b0, mantL} + {1'b0, mantS})
                                     : ({1'b0, mantL} - {1'b0, mantS});

    assign ovfValue = SAT_OVF ? {signL, FP16_MAXF[EXP_HI:0]}
                              : {signL, EXP_MAX, 10'b0};

    fp16_norm_step uNormStep (
        .sumIn     (sumReg),
        .expIn     (expWork),
        .sumOut    (normSum),
        .expOut    (normExp),
        .isZero    (normZero),
        .isNormal  (normDone),
        .overflow  (normOvf),
        .underflow (normUnf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= StIdle;
            acc      <= FP16_ZERO;
            done     <= 1'b0;
            busy     <= 1'b0;
            opReg    <= '0;
            mantL    <= '0;
            mantS    <= '0;
            signL    <= 1'b0;
            signS    <= 1'b0;
            expWork  <= '0;
            sumReg   <= '0;
            alignCnt <= '0;
        end else if (clear) begin
            state <= StIdle;
            acc   <= FP16_ZERO;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (in_valid && in_ready) begin
                        opReg <= din;
                        state <= StCmp;
                        busy  <= 1'b1;
                    end
                end
                StCmp: begin
                    if (opIsZero) begin
                        state <= StDone;
                        done  <= 1'b1;
                    end else if (accIsZero) begin
                        acc   <= opReg;
                        state <= StDone;
                        done  <= 1'b1;
                    end else begin
                        mantL    <= hiddenMant(lVal[FRAC_HI:FRAC_LO]);
                        mantS    <= alignSkip ? '0 : hiddenMant(sVal[FRAC_HI:FRAC_LO]);
                        signL    <= lVal[SIGN];
                        signS    <= sVal[SIGN];
                        expWork  <= {1'b0, lVal[EXP_HI:EXP_LO]};
                        alignCnt <= expDiff;
                        state    <= (alignSkip || expDiff == '0) ? StAdd : StAlign;
                    end
                end
                StAlign: begin
                    mantS    <= mantS >> 1;
                    alignCnt <= alignCnt - 5'd1;
                    if (alignCnt == 5'd1) begin
                        state <= StAdd;
                    end
                end
                StAdd: begin
                    sumReg <= addSum;
                    state  <= StNorm;
                end
                StNorm: begin
                    if (normZero) begin
                        acc   <= FP16_ZERO;
                        state <= StDone;
                        done  <= 1'b1;
                    end else if (normDone) begin
                        acc   <= {signL, expWork[4:0], sumReg[FRAC_HI:FRAC_LO]};
                        state <= StDone;
                        done  <= 1'b1;
                    end else if (normOvf) begin
                        acc   <= ovfValue;
                        state <= StDone;
                        done  <= 1'b1;
                    end else if (normUnf) begin
                        acc   <= FP16_ZERO;
                        state <= StDone;
                        done  <= 1'b1;
                    end else begin
                        sumReg  <= normSum;
                        expWork <= normExp;
                    end
                end
                StDone: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_acc_16.sv
// tb_fp_acc_16: self-checking bench for fp_acc_16.
//   Two instances (saturating and inf-on-overflow) share one stimulus stream;
//   results and done latency are compared against an arithmetic reference model.
module tb_fp_acc_16;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        in_valid;
    logic [15:0] din;

    logic        readyS, busyS, doneS;
    logic        readyI, busyI, doneI;
    logic [15:0] accS, accI;

    int checks   = 0;
    int failures = 0;

    logic [15:0] refSat;
    logic [15:0] refInf;

    always #5 clk = ~clk;

    fp_acc_16 #(.SAT_OVF(1'b1)) dutSat (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (readyS),
        .din      (din),
        .acc      (accS),
        .busy     (busyS),
        .done     (doneS)
    );

    fp_acc_16 #(.SAT_OVF(1'b0)) dutInf (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (readyI),
        .din      (din),
        .acc      (accI),
        .busy     (busyI),
        .done     (doneI)
    );

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: result of adding operand b into accumulator a, and cycles from
    // the accept edge to the done pulse (the pulse cycle included).
    function automatic void refAdd(input logic [15:0] a, input logic [15:0] b, input bit sat,
                                   output logic [15:0] r, output int lat);
        logic [15:0] bigV, smallV;
        int eL, eS, d, mL, mS, sum, e, p, sh, normCyc, alignCyc;
        if (b[14:10] == 5'd0) begin
            r = a; lat = 2; return;
        end
        if (a[14:10] == 5'd0) begin
            r = b; lat = 2; return;
        end
        if (b[14:0] > a[14:0]) begin
            bigV = b; smallV = a;
        end else begin
            bigV = a; smallV = b;
        end
        eL = int'(bigV[14:10]);
        eS = int'(smallV[14:10]);
        d  = eL - eS;
        mL = 1024 + int'(bigV[9:0]);
        if (d >= 11) begin
            mS = 0; alignCyc = 0;
        end else begin
            mS = (1024 + int'(smallV[9:0])) >> d; alignCyc = d;
        end
        sum = (bigV[15] == smallV[15]) ? mL + mS : mL - mS;
        e   = eL;
        if (sum == 0) begin
            r = 16'h0000; normCyc = 1;
        end else if (sum >= 2048) begin
            e = e + 1;
            if (e >= 31) begin
                r = sat ? {bigV[15], 15'h7BFF} : {bigV[15], 15'h7C00};
                normCyc = 1;
            end else begin
                r = {bigV[15], 5'(e), 10'((sum >> 1) & 1023)};
                normCyc = 2;
            end
        end else if (sum >= 1024) begin
            r = {bigV[15], 5'(e), 10'(sum & 1023)}; normCyc = 1;
        end else begin
            p = 0;
            for (int i = 0; i < 10; i++) begin
                if (((sum >> i) & 1) == 1) p = i;
            end
            sh = 10 - p;
            if (e <= sh) begin
                r = 16'h0000; normCyc = e;
            end else begin
                r = {bigV[15], 5'(e - sh), 10'((sum << sh) & 1023)}; normCyc = sh + 1;
            end
        end
        lat = 3 + alignCyc + normCyc;
    endfunction

    task automatic runOp(input logic [15:0] operand, input string tag);
        logic [15:0] wantS, wantI;
        int latS, latI, k;
        refAdd(refSat, operand, 1'b1, wantS, latS);
        refAdd(refInf, operand, 1'b0, wantI, latI);
        checkEq({tag, ":ready"}, {30'd0, readyS, readyI}, 32'd3);
        in_valid = 1'b1;
        din      = operand;
        tick();
        in_valid = 1'b0;
        din      = 16'($urandom);
        k = 1;
        while (!doneS && k < 64) begin
            tick();
            k++;
        end
        checkEq({tag, ":latency"}, k, latS);
        checkEq({tag, ":done"}, {30'd0, doneS, doneI}, 32'd3);
        checkEq({tag, ":busy"}, {30'd0, busyS, busyI}, 32'd3);
        checkEq({tag, ":accSat"}, accS, wantS);
        checkEq({tag, ":accInf"}, accI, wantI);
        tick();
        checkEq({tag, ":idle"}, {26'd0, doneS, busyS, readyS, doneI, busyI, readyI}, 32'b001001);
        refSat = wantS;
        refInf = wantI;
    endtask

    task automatic doClear(input string tag);
        clear = 1'b1;
        #1;
        checkEq({tag, ":readyInClear"}, {30'd0, readyS, readyI}, 32'd0);
        @(posedge clk);
        #1;
        checkEq({tag, ":clearedState"},
                {accS, accI}, 32'd0);
        checkEq({tag, ":clearedFlags"}, {28'd0, busyS, doneS, busyI, doneI}, 32'd0);
        clear = 1'b0;
        #1;
        checkEq({tag, ":readyAfterClear"}, {30'd0, readyS, readyI}, 32'd3);
        refSat = 16'h0000;
        refInf = 16'h0000;
    endtask

    // Accept an operand, clear it after waitCycles cycles, confirm no done pulse follows.
    task automatic abortOp(input logic [15:0] operand, input int waitCycles, input string tag);
        bit sawDone;
        in_valid = 1'b1;
        din      = operand;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < waitCycles; i++) tick();
        checkEq({tag, ":midFlight"}, {30'd0, busyS, doneS}, 32'd2);
        doClear(tag);
        sawDone = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (doneS || doneI || busyS || busyI) sawDone = 1'b1;
            tick();
        end
        checkEq({tag, ":noDoneAfterAbort"}, {31'd0, sawDone}, 32'd0);
    endtask

    function automatic logic [15:0] randOperand();
        int r;
        logic [4:0] ex;
        r = int'($urandom_range(0, 99));
        if (r < 8) return {1'($urandom), 5'd0, 10'($urandom)};
        if (r < 22 && refSat[14:10] != 5'd0)
            return {~refSat[15], refSat[14:10], refSat[9:0] ^ 10'($urandom_range(0, 7))};
        if (r < 50 && refSat[14:10] > 5'd3 && refSat[14:10] < 5'd28) begin
            ex = refSat[14:10] + 5'($urandom_range(0, 6)) - 5'd3;
            return {1'($urandom), ex, 10'($urandom)};
        end
        return {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b1;
        din      = 16'h3C00;
        refSat   = 16'h0000;
        refInf   = 16'h0000;
        tick();
        tick();
        checkEq("reset:acc", {accS, accI}, 32'd0);
        checkEq("reset:flags", {28'd0, busyS, doneS, busyI, doneI}, 32'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        checkEq("reset:ready", {30'd0, readyS, readyI}, 32'd3);
        tick();
        checkEq("reset:ignoredValid", {15'd0, busyS, accS}, 32'd0);

        runOp(16'h3C00, "pass3c00");
        checkEq("pass3c00:const", accS, 16'h3C00);
        runOp(16'h3C00, "one+one");
        checkEq("one+one:const", accS, 16'h4000);
        runOp(16'hBC00, "two-one");
        checkEq("two-one:const", accS, 16'h3C00);
        runOp(16'hBC00, "cancel");
        checkEq("cancel:const", accS, 16'h0000);
        runOp(16'h3C00, "reload");
        runOp(16'h1400, "d10");
        checkEq("d10:const", accS, 16'h3C01);
        runOp(16'h1000, "d11");
        checkEq("d11:const", accS, 16'h3C01);

        doClear("preOvf");
        runOp(16'h7BFF, "loadMax");
        runOp(16'h7BFF, "ovf");
        checkEq("ovf:sat", accS, 16'h7BFF);
        checkEq("ovf:inf", accI, 16'h7C00);
        runOp(16'h0200, "subnormal");
        checkEq("subnormal:sat", accS, 16'h7BFF);
        doClear("postOvf");

        runOp(16'h3C00, "preAbort");
        abortOp(16'h3000, 2, "abortAlign");
        runOp(16'hC000, "afterAbort");
        checkEq("afterAbort:const", accS, 16'hC000);

        for (int i = 0; i < 200; i++) begin
            if (refSat != refInf || $urandom_range(0, 19) == 0) doClear("rndClear");
            if ($urandom_range(0, 15) == 0) begin
                abortOp(randOperand(), 1, "rndAbort");
            end else begin
                runOp(randOperand(), "rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_acc_16.md
Name: fp_acc_16

Overview:
Multicycle IEEE-754 half-precision accumulator that consumes the products of the FP16 multiplier and keeps a running sum, forming a multiply-accumulate path for the multicycle datapath. Each accepted operand is added into an internal FP16 accumulator over several cycles: compare/swap, one-bit-per-cycle alignment, add/subtract, one-bit-per-cycle normalization. Arithmetic conventions match the multiplier: no NaN/Inf handling, subnormals flushed to zero, truncation only (no rounding).

Parameters:
SAT_OVF, 1, exponent overflow: 1 = saturate to ±max finite (0x7BFF/0xFBFF); 0 = produce ±inf pattern (exp=31, frac=0)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; one clock, one synchronous active-high reset
clear  input  1  synchronous accumulator clear, any state
in_valid  input  1  din valid
in_ready  output  1  block can accept din this cycle
din  input  16  FP16 operand (typically the multiplier product)
acc  output  16  current accumulator value (registered)
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when acc has been updated for the last accepted operand

Behaviour:
- Reset values: acc=0x0000, state=IDLE, done=0, busy=0. in_ready is 1 in IDLE when clear=0.
- Priority: reset > clear > normal operation. clear in any state: acc=0x0000, state→IDLE, done=0 next cycle, and the in-flight operand is discarded. in_ready=0 while clear=1.
- Handshake: the operand is accepted on a rising edge where in_valid && in_ready. in_ready=0 in every state except IDLE. din is sampled only on acceptance.
- States: IDLE, CMP, ALIGN, ADD, NORM, DONE.
- IDLE: on accept, latch din and go to CMP.
- CMP (1 cycle):
  - If din.exp==0, the operand is zero: acc is unchanged. Go to DONE.
  - Else if acc.exp==0: acc←din. Go to DONE.
  - Otherwise form 11-bit mantissas {1,frac}. L = the operand with the larger {exp,frac} magnitude, S = the other; ties pick acc as L.
  - d = expL−expS. If d≥11, S mantissa is zeroed and ALIGN is skipped.
  - If d==0, go to ADD; else go to ALIGN.
- ALIGN: S mantissa >>1 per cycle (truncating) for exactly d cycles, then go to ADD.
- ADD (1 cycle): 12-bit sum = mL+mS if signs are equal, else mL−mS (never negative). Result sign = sign of L. Result exp = expL.
- NORM (shifts+1 cycles), one action per cycle:
  - sum==0: acc←0x0000 (positive zero), go to DONE.
  - sum[11]=1: sum>>1 (truncate), exp+1. If exp reaches 31, acc←overflow value per SAT_OVF and go to DONE.
  - sum[11:10]==01: acc←{sign, exp, sum[9:0]}, go to DONE.
  - else: sum<<1, exp−1. If exp reaches 0, acc←0x0000 (flush), go to DONE.
- DONE (1 cycle): done=1, busy=1, then IDLE. acc is stable from DONE onward.
- Latency from the accept edge to the done pulse:
  - Zero/passthrough path: 2 cycles (CMP, DONE).
  - General path: 1 + d' + 1 + (n+1) + 1 cycles, where d' = min(d, 0 if d≥11) and n = number of normalization shifts.
- No operand queueing: back-to-back operands are accepted only after returning to IDLE.

Decomposition:
- Shared package fp16_pkg: field positions (SIGN=15, EXP=14:10, FRAC=9:0), constants EXP_MAX=31, FP16_MAXF=0x7BFF, FP16_ZERO=0x0000, the state encoding, and a helper for the 11-bit hidden-bit mantissa.
- One natural sub-module: fp16_norm_step, a combinational single-step normalizer. It takes {sum, exp} and returns the next {sum, exp} plus the done/overflow/underflow flags used in NORM.

Test Plan:
- reset held 2 cycles -> acc=0x0000, busy=0, done=0, in_ready=1; in_valid during reset is ignored.
- acc=0, din=0x3C00 -> acc=0x3C00, done 2 cycles after accept. Then din=0x3C00 -> acc=0x4000: CMP1 + ADD1 + NORM2 + DONE1, done 5 cycles after accept.
- acc=0x4000, din=0xBC00 -> acc=0x3C00 (d=1, one ALIGN cycle). Then din=0xBC00 -> acc=0x0000 (exact cancel, positive zero).
- acc=0x3C00, din=0x1400 -> acc=0x3C01 (d=10). Then din=0x1000 -> acc unchanged 0x3C01 (d=11, ALIGN skipped).
- acc=0x7BFF, din=0x7BFF -> SAT_OVF=1: acc=0x7BFF; SAT_OVF=0: acc=0x7C00. din=0x0200 (subnormal) -> acc unchanged.
- clear asserted during ALIGN -> next cycle acc=0x0000, busy=0, in_ready=1 (after clear deasserts), no done pulse. A following din=0xC000 -> acc=0xC000.
